// File: rtl/dsmod_n_pkg.sv
// Shared constants and helpers for the dsmod_n delta-sigma modulator.
// LFSR constants are only consumed when DSMOD_DITHER_EN is defined.
package dsmod_n_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int sat(input int v, input int w);
        int lo;
        int hi;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dsmod_n_core.sv
// One modulator channel: sample hold register, saturating integrators i1/i2
// and the registered 1-bit output.
module dsmod_n_core
    import dsmod_n_pkg::*;
#(
    parameter int n     = 4,
    parameter int ORDER = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              tick,
    input  logic              load,
    input  logic [n-1:0]      in,
    input  logic signed [1:0] dither,
    output logic              out
);

    localparam int W1 = n + 2;
    localparam int W2 = n + 4;

    logic signed [n-1:0]  hold;
    logic signed [W1-1:0] i1;
    logic signed [W2-1:0] i2;

    int   x;
    int   fb;
    int   s1;
    int   s2;
    logic nout;

    // Sums are formed in int so the saturation sees the true value, never a wrapped one.
    always_comb begin
        x    = load ? int'($signed(in)) : int'(hold);
        fb   = out ? (1 << (n - 1)) : -(1 << (n - 1));
        s1   = sat(int'(i1) + x + int'(dither) - fb, W1);
        s2   = sat(int'(i2) + s1 - fb, W2);
        nout = (ORDER == 2) ? (s2 >= 0) : (s1 >= 0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hold <= '0;
            i1   <= '0;
            i2   <= '0;
            out  <= 1'b0;
        end else if (tick) begin
            if (load) hold <= in;
            i1  <= s1[W1-1:0];
            i2  <= (ORDER == 2) ? s2[W2-1:0] : '0;
            out <= nout;
        end
    end

endmodule

// File: rtl/dsmod_n.sv
// Multi-channel 1st/2nd order delta-sigma DAC modulator with divided tick and
// oversampled input strobe. Optional dither: define DSMOD_DITHER_EN.
module dsmod_n
    import dsmod_n_pkg::*;
#(
    parameter int n     = 4,
    parameter int CH    = 1,
    parameter int ORDER = 2,
    parameter int DIV   = 1,
    parameter int OSR   = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [CH*n-1:0] in,
    output logic            in_stb,
    output logic [CH-1:0]   out
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

    if (ORDER != 1 && ORDER != 2) begin : g_order_chk
        $error("dsmod_n: ORDER must be 1 or 2");
    end
    if (DIV < 1 || OSR < 1) begin : g_rate_chk
        $error("dsmod_n: DIV and OSR must be >= 1");
    end

    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] osr_cnt;
    logic          tick;
    logic          load;

    assign tick   = (tick_cnt == TW'(DIV - 1));
    assign load   = tick && (osr_cnt == '0);
    assign in_stb = load && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_cnt <= '0;
            osr_cnt  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) osr_cnt <= (osr_cnt == OW'(OSR - 1)) ? '0 : osr_cnt + 1'b1;
        end
    end

`ifdef DSMOD_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (clr)       lfsr <= LFSR_SEED;
        else if (tick) lfsr <= lfsr_next(lfsr);
    end
`endif

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [1:0] d;
`ifdef DSMOD_DITHER_EN
        assign d = lfsr[c % 16] ? 2'sb01 : 2'sb11;
`else
        assign d = 2'sb00;
`endif
        dsmod_n_core #(.n(n), .ORDER(ORDER)) u_core (
            .clk    (clk),
            .clr    (clr),
            .tick   (tick),
            .load   (load),
            .in     (in[c*n +: n]),
            .dither (d),
            .out    (out[c])
        );
    end

endmodule

// File: tb/tb_dsmod_n.sv
// Bench for dsmod_n: three configurations driven together, checked every cycle
// against a per-tick arithmetic model, plus hand-computed density/timing pins.
module tb_dsmod_n;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in0;
    logic [1:0] out0;
    logic       stb0;
    logic [3:0] in1;
    logic       out1;
    logic       stb1;
    logic [5:0] in2;
    logic       out2;
    logic       stb2;

    int checks   = 0;
    int failures = 0;

    // Model: edges since release and ticks taken per unit; state per channel slot
    int e[3];
    int t[3];
    int mi1[4];
    int mi2[4];
    int mo[4];
    int mh[4];

    always #5 clk = ~clk;

    dsmod_n #(.n(4), .CH(2), .ORDER(2), .DIV(1), .OSR(1)) u0 (
        .clk(clk), .clr(clr), .in(in0), .in_stb(stb0), .out(out0));
    dsmod_n #(.n(4), .CH(1), .ORDER(1), .DIV(3), .OSR(4)) u1 (
        .clk(clk), .clr(clr), .in(in1), .in_stb(stb1), .out(out1));
    dsmod_n #(.n(6), .CH(1), .ORDER(2), .DIV(2), .OSR(3)) u2 (
        .clk(clk), .clr(clr), .in(in2), .in_stb(stb2), .out(out2));

    function automatic int pdiv(input int u);
        case (u)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int posr(input int u);
        case (u)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int slot_n(input int s);
        return (s == 3) ? 6 : 4;
    endfunction

    function automatic int slot_ord(input int s);
        return (s == 2) ? 1 : 2;
    endfunction

    function automatic int clamp(input int v, input int w);
        int lim;
        lim = 2 ** (w - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim)    return -lim;
        return v;
    endfunction

    function automatic int cur_in(input int s);
        case (s)
            0:       return int'($signed(in0[3:0]));
            1:       return int'($signed(in0[7:4]));
            2:       return int'($signed(in1));
            default: return int'($signed(in2));
        endcase
    endfunction

    function automatic int exp_stb(input int u);
        return (!clr && ((e[u] + 1) % pdiv(u) == 0) && (t[u] % posr(u) == 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            e[u] = 0;
            t[u] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            mi1[s] = 0;
            mi2[s] = 0;
            mo[s]  = 0;
            mh[s]  = 0;
        end
    endtask

    task automatic chan_step(input int s, input bit ld);
        int nb;
        int fb;
        int a;
        int b;
        nb = slot_n(s);
        if (ld) mh[s] = cur_in(s);
        fb = (mo[s] != 0) ? 2 ** (nb - 1) : -(2 ** (nb - 1));
        a  = clamp(mi1[s] + mh[s] - fb, nb + 2);
        if (slot_ord(s) == 2) begin
            b      = clamp(mi2[s] + a - fb, nb + 4);
            mi2[s] = b;
            mo[s]  = (b >= 0) ? 1 : 0;
        end else begin
            mo[s] = (a >= 0) ? 1 : 0;
        end
        mi1[s] = a;
    endtask

    task automatic model_step();
        bit ld;
        if (clr) begin
            model_reset();
        end else begin
            for (int u = 0; u < 3; u++) begin
                e[u]++;
                if (e[u] % pdiv(u) == 0) begin
                    ld = (t[u] % posr(u) == 0);
                    if (u == 0) begin
                        chan_step(0, ld);
                        chan_step(1, ld);
                    end else begin
                        chan_step(u + 1, ld);
                    end
                    t[u]++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [3:0] pick4();
        logic [31:0] r;
        r = $urandom;
        case (r[31:30])
            2'd0:    return 4'h8;
            2'd1:    return 4'h7;
            default: return r[3:0];
        endcase
    endfunction

    function automatic logic [5:0] pick6();
        logic [31:0] r;
        r = $urandom;
        case (r[31:30])
            2'd0:    return 6'h20;
            2'd1:    return 6'h1f;
            default: return r[5:0];
        endcase
    endfunction

    // One clock: compare outputs, apply next inputs, check strobe, advance model.
    task automatic run(input bit c, input bit rnd);
        @(negedge clk);
        chk("out_u0c0", int'(out0[0]), mo[0]);
        chk("out_u0c1", int'(out0[1]), mo[1]);
        chk("out_u1", int'(out1), mo[2]);
        chk("out_u2", int'(out2), mo[3]);
        clr = c;
        if (rnd) begin
            in0 = {pick4(), pick4()};
            in1 = pick4();
            in2 = pick6();
        end
        #1;
        chk("stb_u0", int'(stb0), exp_stb(0));
        chk("stb_u1", int'(stb1), exp_stb(1));
        chk("stb_u2", int'(stb2), exp_stb(2));
        model_step();
    endtask

    initial begin
        int s0;
        int s1;
        int su1;
        int f1;
        int f2;

        clr = 1'b1;
        in0 = '0;
        in1 = '0;
        in2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out0", int'(out0), 0);
        chk("rst_out1", int'(out1), 0);
        chk("rst_out2", int'(out2), 0);
        chk("rst_stb", int'({stb0, stb1, stb2}), 0);

        // ch0=7, ch1=-8 on u0; u1 at +7 with tick every 3 clk
        in0 = 8'h87;
        in1 = 4'h7;
        in2 = 6'h00;
        s0 = 0; s1 = 0; su1 = 0; f1 = -1; f2 = -1;
        for (int k = 0; k < 300; k++) begin
            run(1'b0, 1'b0);
            if (k >= 44) begin
                s0 += int'(out0[0]);
                s1 += int'(out0[1]);
            end
            if (k >= 60 && k < 108) su1 += int'(out1);
            if (stb1) begin
                if (f1 < 0)      f1 = k;
                else if (f2 < 0) f2 = k;
            end
        end
        chk_rng("dens_o2_x7", s0, 238, 242);
        chk("dens_o2_xm8", s1, 0);
        chk("dens_o1_x7_48clk", su1, 45);
        chk("first_stb_u1", f1, 2);
        chk("second_stb_u1", f2, 14);

        // Single-cycle clr mid-stream, then ch0=0, ch1=3, u1 at -8
        in0 = 8'h30;
        in1 = 4'h8;
        in2 = 6'h2a;
        run(1'b1, 1'b0);
        s0 = 0; s1 = 0; su1 = 0;
        for (int k = 0; k < 300; k++) begin
            run(1'b0, 1'b0);
            if (k == 0) begin
                chk("clr_out0", int'(out0), 0);
                chk("clr_out1", int'(out1), 0);
            end
            if (k >= 44) begin
                s0 += int'(out0[0]);
                s1 += int'(out0[1]);
            end
            if (k < 60) su1 += int'(out1);
        end
        chk_rng("dens_o2_x0", s0, 126, 130);
        chk_rng("dens_o2_x3", s1, 174, 178);
        chk("o1_xm8_one_tick", su1, 3);

        // Random inputs including the extremes, occasional clr
        for (int k = 0; k < 3000; k++) begin
            run(($urandom_range(0, 149) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
